// File: rtl/adpll_loop_filter_pgm_pkg.sv
// adpll_pkg: register indices, defaults and saturating add for the ADPLL loop filter
package adpll_pkg;
  localparam logic [2:0] PSEL_KP = 3'd0;
  localparam logic [2:0] PSEL_KI = 3'd1;
  localparam logic [2:0] PSEL_CINIT = 3'd2;
  localparam logic [2:0] PSEL_LTH = 3'd3;
  localparam logic [2:0] PSEL_LCNT = 3'd4;
  localparam int DEF_KP = 1;
  localparam int DEF_KI = 3;
  localparam int DEF_LTH = 1;
  localparam int DEF_LCNT = 16;
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b,
                                                 input logic signed [31:0] lo, input logic signed [31:0] hi);
    logic signed [31:0] s;
    s = a + b;
    return s < lo ? lo : s > hi ? hi : s;
  endfunction
endpackage

// File: rtl/adpll_loop_filter_pgm_if.sv
// adpll_loop_filter_pgm_if: phase-error, programming and DCO/debug signals of the loop filter
interface adpll_loop_filter_pgm_if #(parameter int W = 8, parameter int PW = 5);
  logic err_valid;
  logic [W-1:0] err_mag;
  logic err_sign;
  logic clr;
  logic pgm;
  logic [2:0] param_sel;
  logic [PW-1:0] pgm_value;
  logic out_sel;
  logic [W-1:0] dco_code;
  logic code_valid;
  logic [W-1:0] dout;
  logic sign;
  logic locked;
  modport master(output err_valid, err_mag, err_sign, clr, pgm, param_sel, pgm_value, out_sel,
                 input dco_code, code_valid, dout, sign, locked);
  modport slave(input err_valid, err_mag, err_sign, clr, pgm, param_sel, pgm_value, out_sel,
                output dco_code, code_valid, dout, sign, locked);
endinterface

// File: rtl/adpll_loop_filter_pgm_lock_det.sv
// adpll_lock_det: counts consecutive in-threshold error samples and flags lock
module adpll_lock_det import adpll_pkg::*; #(
  parameter int W = 8,
  parameter int LCW = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic err_valid,
  input  logic [W-1:0] err_mag,
  input  logic [W-1:0] thresh,
  input  logic [LCW-1:0] lock_count,
  output logic locked
);
  localparam logic signed [31:0] CNT_MAX = (32'sd1 <<< LCW) - 32'sd1;
  logic [LCW-1:0] cnt, cnt_n;
  logic in_th;
  always_comb begin
    in_th = err_mag <= thresh;
    cnt_n = in_th ? LCW'(sat_add($signed(32'(cnt)), 32'sd1, 32'sd0, CNT_MAX)) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      locked <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      locked <= 1'b0;
    end else if (err_valid) begin
      cnt <= cnt_n;
      locked <= in_th && cnt_n >= lock_count;
    end
endmodule

// File: rtl/adpll_loop_filter_pgm.sv
// adpll_loop_filter_pgm: programmable two-stage PI loop filter with saturation and lock detect
module adpll_loop_filter_pgm import adpll_pkg::*; #(
  parameter int W = 8,
  parameter int ACC_W = 12,
  parameter int PW = 5,
  parameter int LCW = 6
) (
  input logic clk,
  input logic rst_n,
  adpll_loop_filter_pgm_if.slave bus
);
  localparam logic [W-1:0] CODE_DEF = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [31:0] ACC_MIN = -(32'sd1 <<< (ACC_W-1));
  localparam logic signed [31:0] ACC_MAX = (32'sd1 <<< (ACC_W-1)) - 32'sd1;
  localparam logic signed [31:0] CODE_MAX = (32'sd1 <<< W) - 32'sd1;
  logic [PW-1:0] kp, ki;
  logic [W-1:0] code_init, lock_thresh;
  logic [LCW-1:0] lock_count;
  logic pgm_q, wr, s1_valid;
  logic signed [W:0] p_s, i_s;
  logic signed [ACC_W-1:0] integ;
  logic [W-1:0] p_mag, i_mag, dco_d;
  logic signed [31:0] integ_w, dco_w, integ_abs;
  always_comb begin
    wr = bus.pgm & ~pgm_q;
    p_mag = bus.err_mag >> kp;
    i_mag = bus.err_mag >> ki;
    integ_w = bus.clr ? 32'sd0 : s1_valid ? sat_add(32'(integ), 32'(i_s), ACC_MIN, ACC_MAX) : 32'(integ);
    dco_w = sat_add(32'($signed({1'b0, code_init})) + 32'(p_s), integ_w, 32'sd0, CODE_MAX);
    dco_d = bus.clr ? CODE_DEF : s1_valid ? W'(dco_w) : bus.dco_code;
    integ_abs = integ_w < 0 ? -integ_w : integ_w;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      kp <= PW'(DEF_KP);
      ki <= PW'(DEF_KI);
      code_init <= CODE_DEF;
      lock_thresh <= W'(DEF_LTH);
      lock_count <= LCW'(DEF_LCNT);
      pgm_q <= 1'b0;
      s1_valid <= 1'b0;
      p_s <= '0;
      i_s <= '0;
      integ <= '0;
      bus.dco_code <= CODE_DEF;
      bus.code_valid <= 1'b0;
      bus.dout <= CODE_DEF;
      bus.sign <= 1'b0;
    end else begin
      pgm_q <= bus.pgm;
      s1_valid <= bus.err_valid & ~bus.clr;
      if (bus.err_valid) begin
        p_s <= bus.err_sign ? -$signed({1'b0, p_mag}) : $signed({1'b0, p_mag});
        i_s <= bus.err_sign ? -$signed({1'b0, i_mag}) : $signed({1'b0, i_mag});
      end
      integ <= ACC_W'(integ_w);
      bus.dco_code <= dco_d;
      bus.code_valid <= s1_valid & ~bus.clr;
      bus.dout <= bus.out_sel ? (integ_abs > CODE_MAX ? '1 : W'(integ_abs)) : dco_d;
      bus.sign <= bus.out_sel & (integ_w < 0);
      // clear wins over a coincident programming edge
      if (bus.clr) begin
        kp <= PW'(DEF_KP);
        ki <= PW'(DEF_KI);
        code_init <= CODE_DEF;
        lock_thresh <= W'(DEF_LTH);
        lock_count <= LCW'(DEF_LCNT);
      end else if (wr) begin
        if (bus.param_sel == PSEL_KP) kp <= bus.pgm_value;
        if (bus.param_sel == PSEL_KI) ki <= bus.pgm_value;
        if (bus.param_sel == PSEL_CINIT) code_init <= W'(bus.pgm_value) << (W - PW);
        if (bus.param_sel == PSEL_LTH) lock_thresh <= W'(bus.pgm_value);
        if (bus.param_sel == PSEL_LCNT) lock_count <= LCW'(bus.pgm_value);
      end
    end
  adpll_lock_det #(.W(W), .LCW(LCW)) u_lock (
    .clk(clk),
    .rst_n(rst_n),
    .clr(bus.clr),
    .err_valid(bus.err_valid),
    .err_mag(bus.err_mag),
    .thresh(lock_thresh),
    .lock_count(lock_count),
    .locked(bus.locked)
  );
endmodule

// File: tb/tb_adpll_loop_filter_pgm.sv
// tb_adpll_loop_filter_pgm: vector table plus scoreboarded sequences for the PI loop filter
module tb_adpll_loop_filter_pgm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  adpll_loop_filter_pgm_if #(.W(8), .PW(5)) bus ();
  adpll_loop_filter_pgm #(.W(8), .ACC_W(12), .PW(5), .LCW(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct { int code; int cyc; } exp_t;
  typedef struct { int mag; bit sgn; bit osel; int code; int dout; bit sgn_out; } vec_t;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[10];
  int vec_cnt = 0, err_cnt = 0, cyc = 0;
  int m_kp, m_ki, m_ci, m_integ;
  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
  task automatic model_clr();
    m_kp = 1; m_ki = 3; m_ci = 128; m_integ = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic send(input int mag, input bit sgn);
    int p, i;
    p = mag >> m_kp;
    i = mag >> m_ki;
    if (sgn) begin p = -p; i = -i; end
    m_integ = clamp(m_integ + i, -2048, 2047);
    sb.push_back('{clamp(m_ci + p + m_integ, 0, 255), cyc});
    bus.err_valid = 1'b1;
    bus.err_mag = 8'(mag);
    bus.err_sign = sgn;
    tick();
    bus.err_valid = 1'b0;
  endtask
  task automatic pgm_write(input int sel, input int val, input int hold);
    bus.param_sel = 3'(sel);
    bus.pgm_value = 5'(val);
    bus.pgm = 1'b1;
    idle(hold);
    bus.pgm = 1'b0;
    tick();
    if (sel == 0) m_kp = val;
    if (sel == 1) m_ki = val;
    if (sel == 2) m_ci = val << 3;
  endtask
  task automatic chk_dbg(input string name, input int dout, input int sgn, input int code);
    chk({name, "_dout"}, bus.dout, dout);
    chk({name, "_sign"}, bus.sign, sgn);
    chk({name, "_code"}, bus.dco_code, code);
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (rst_n && bus.code_valid) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL sb_unexpected: code_valid with dco_code=%0d, want no output", bus.dco_code);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_code", bus.dco_code, mon_e.code);
        chk("sb_latency", cyc - mon_e.cyc, 2);
      end
    end
  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.err_valid = 1'b0; bus.err_mag = '0; bus.err_sign = 1'b0; bus.clr = 1'b0;
    bus.pgm = 1'b0; bus.param_sel = '0; bus.pgm_value = '0; bus.out_sel = 1'b0;
    model_clr();
    tbl[0] = '{0, 0, 0, 128, 128, 0};
    tbl[1] = '{16, 0, 1, 138, 2, 0};
    tbl[2] = '{16, 1, 0, 120, 120, 0};
    tbl[3] = '{1, 1, 1, 128, 0, 0};
    tbl[4] = '{0, 1, 0, 128, 128, 0};
    tbl[5] = '{255, 0, 1, 255, 31, 0};
    tbl[6] = '{255, 1, 0, 1, 1, 0};
    tbl[7] = '{100, 1, 1, 66, 12, 1};
    tbl[8] = '{7, 0, 1, 119, 12, 1};
    tbl[9] = '{200, 0, 0, 241, 241, 0};
    #12;
    chk_dbg("rst", 128, 0, 128);
    chk("rst_cv", bus.code_valid, 0);
    chk("rst_locked", bus.locked, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_dbg("rel", 128, 0, 128);
    chk("rel_cv", bus.code_valid, 0);
    foreach (tbl[k]) begin
      bus.out_sel = tbl[k].osel;
      send(tbl[k].mag, tbl[k].sgn);
      tick();
      chk($sformatf("vec%0d_cv", k), bus.code_valid, 1);
      chk_dbg($sformatf("vec%0d", k), tbl[k].dout, tbl[k].sgn_out, tbl[k].code);
    end
    bus.clr = 1'b1; tick(); bus.clr = 1'b0; model_clr();
    pgm_write(0, 0, 1);
    pgm_write(1, 0, 1);
    bus.out_sel = 1'b1;
    repeat (20) send(255, 0);
    idle(3);
    chk_dbg("sat_pos", 255, 0, 255);
    repeat (8) send(255, 1);
    idle(3);
    chk_dbg("sat_pos_exact", 7, 0, 0);
    repeat (12) send(255, 1);
    idle(3);
    chk_dbg("sat_neg", 255, 1, 0);
    pgm_write(0, 31, 1);
    repeat (8) send(255, 0);
    idle(3);
    chk_dbg("sat_neg_exact", 8, 1, 120);
    bus.out_sel = 1'b0;
    bus.clr = 1'b1; tick(); bus.clr = 1'b0; model_clr();
    pgm_write(0, 2, 5);
    send(16, 0); tick();
    chk("pgm_kp2", bus.dco_code, 134);
    pgm_write(6, 0, 1);
    send(16, 0); tick();
    chk("pgm_reserved", bus.dco_code, 136);
    bus.param_sel = 3'd0; bus.pgm_value = 5'd0; bus.pgm = 1'b1; bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    tick();
    bus.pgm = 1'b0;
    tick();
    model_clr();
    send(16, 0); tick();
    chk("clr_over_pgm", bus.dco_code, 138);
    pgm_write(2, 4, 1);
    send(0, 0); tick();
    chk("pgm_cinit", bus.dco_code, 34);
    bus.clr = 1'b1; tick(); bus.clr = 1'b0; model_clr();
    chk("lock_clr", bus.locked, 0);
    repeat (15) send(1, 0);
    chk("lock_15", bus.locked, 0);
    send(1, 0);
    chk("lock_16", bus.locked, 1);
    send(3, 0);
    chk("lock_drop", bus.locked, 0);
    repeat (15) send(1, 0);
    chk("relock_15", bus.locked, 0);
    send(1, 0);
    chk("relock_16", bus.locked, 1);
    pgm_write(3, 4, 1);
    send(3, 0);
    chk("lock_th4", bus.locked, 1);
    pgm_write(4, 0, 1);
    send(5, 0);
    chk("lcnt0_out", bus.locked, 0);
    send(2, 0);
    chk("lcnt0_in", bus.locked, 1);
    bus.out_sel = 1'b1;
    send(200, 0);
    send(200, 0);
    send(2, 0);
    chk("pre_rst_cv", bus.code_valid, 1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_clr();
    #1;
    chk_dbg("async_rst", 128, 0, 128);
    chk("async_rst_cv", bus.code_valid, 0);
    chk("async_rst_locked", bus.locked, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    send(16, 0); tick();
    chk("pre_clr_code", bus.dco_code, 138);
    bus.err_valid = 1'b1; bus.err_mag = 8'd16; bus.err_sign = 1'b0;
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0; bus.err_valid = 1'b0;
    model_clr();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("clr_kill_cv%0d", k), bus.code_valid, 0);
      tick();
    end
    chk_dbg("clr_kill", 0, 0, 128);
    idle(3);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/adpll_loop_filter_pgm.md
Name: adpll_loop_filter_pgm

Overview:
- Parametrised successor to the fixed 5-bit ADPLL PI filter: W-bit programmable proportional-integral loop filter with a lock detector.
- Sits between the TDC/ones-counter (sign-magnitude phase error) and the DCO.
- Runtime-programmable gains, centre code and lock criteria, written through the clr/pgm/param_sel/pgm_value interface already used at chip top.
- Adds saturation, a two-stage pipeline and lock detection.

Parameters:
- W, 8: error magnitude and DCO code width (W >= PW).
- ACC_W, 12: signed integrator width (ACC_W > W).
- PW, 5: programming value width.
- LCW, 6: lock counter width.

Ports:
- clk  in  1  sample clock.
- rst_n  in  1  asynchronous active-low reset.
- err_valid  in  1  one-cycle strobe, one per reference edge.
- err_mag  in  W  phase error magnitude.
- err_sign  in  1  1 = negative error.
- clr  in  1  synchronous clear of registers, integrator and pipeline.
- pgm  in  1  program request, level-held.
- param_sel  in  3  register select.
- pgm_value  in  PW  value to write.
- out_sel  in  1  0 = DCO code on dout, 1 = integrator on dout.
- dco_code  out  W  unsigned DCO control word.
- code_valid  out  1  one-cycle strobe when dco_code updates.
- dout  out  W  debug magnitude.
- sign  out  1  debug sign.
- locked  out  1  lock indicator.

Behaviour:
- Reset (rst_n low, async):
  - Registers take their defaults.
  - Integrator = 0; lock counter = 0.
  - dco_code = 2^(W-1); code_valid = 0; locked = 0; dout = 2^(W-1); sign = 0.
- Register bank, indexed by param_sel:
  - 0 KP_SHIFT, default 1.
  - 1 KI_SHIFT, default 3.
  - 2 CODE_INIT, default 2^(W-1); written as pgm_value << (W-PW).
  - 3 LOCK_THRESH, default 1, zero-extended.
  - 4 LOCK_COUNT, default 16, zero-extended.
  - 5-7 reserved: writes ignored.
- Programming:
  - Write occurs on the rising edge of pgm (registered edge detect). Exactly one write per pgm pulse, however long pgm is held.
  - clr has priority over pgm and err_valid in the same cycle.
  - clr restores defaults, zeroes integrator and lock counter, kills in-flight pipeline data (no code_valid), and sets dco_code = default CODE_INIT.
- Stage 1 (cycle after err_valid):
  - p = err_mag >> KP_SHIFT; i = err_mag >> KI_SHIFT. Logical shift on magnitude; truncation toward zero; shift >= W gives 0.
  - Apply sign to get signed p and i.
  - err_sign = 1 with err_mag = 0 is treated as zero.
- Stage 2:
  - integ <= clamp(integ + i) to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - dco_code <= clamp(CODE_INIT + p + integ_new) to [0, 2^W-1].
  - code_valid pulses.
  - Latency: err_valid at cycle N gives code_valid at N+2. Back-to-back err_valid every cycle is supported at full throughput.
- Lock detector, evaluated on each err_valid:
  - If err_mag <= LOCK_THRESH: counter increments, saturating at 2^LCW-1. Otherwise counter = 0 and locked = 0 on the next cycle.
  - locked = 1 once counter >= LOCK_COUNT.
  - LOCK_COUNT = 0 means locked whenever the last sample is in threshold.
- Debug outputs (registered, updated every cycle):
  - out_sel = 0: dout = dco_code, sign = 0.
  - out_sel = 1: dout = |integ| clamped to 2^W-1, sign = integ < 0.
- Register changes take effect on the next err_valid; the integrator is not rescaled.

Decomposition:
- Package adpll_pkg holds:
  - Register index constants (PSEL_KP=0 .. PSEL_LCNT=4).
  - Default values.
  - A saturating-add function, reused by the integrator and output clamps.
- One sub-module, adpll_lock_det: counter, threshold compare and locked flag.
- Register bank and PI datapath stay in the top module.

Test Plan (W=8, ACC_W=12, PW=5):
- Reset, then release:
  - Required: dco_code=128, dout=128, sign=0, code_valid=0, locked=0.
  - err_valid with err_mag=0 gives code_valid two cycles later and dco_code=128.
- Defaults, single err_mag=16, err_sign=0:
  - Required: p=8, i=2, integ=2, dco_code=138 at N+2.
  - Then err_mag=16, err_sign=1: integ=0, dco_code=120.
  - out_sel=1 after the first sample: dout=2, sign=0.
- KP=0, KI=0 programmed; 20 consecutive samples of err_mag=255 positive:
  - Required: dco_code clamps at 255; integ saturates at 2047.
  - out_sel=1: dout=255, sign=0.
  - Opposite sign: codes clamp at 0; integ stops at -2048.
- Programming:
  - pgm held 5 cycles with param_sel=0, value=2: exactly one write, KP=2 verified via the next output.
  - param_sel=6 write: no register changes.
  - clr with pgm high in the same cycle: defaults win.
- Lock:
  - 16 samples of err_mag=1: locked rises after the 16th.
  - One sample of err_mag=3: locked falls next cycle and counter restarts.
  - LOCK_THRESH programmed to 4: err_mag=3 samples count.
- Reset and clear mid-operation:
  - err_valid coincident with clr: no code_valid at N+2, dco_code=128, integ=0.
  - rst_n asserted asynchronously mid-pipeline: all outputs at reset values immediately, without a clock edge.
